banco_registradores_param: RTL
==============================

Name: banco_registradores_param

Overview:
Parametrised register bank for the processor datapath: NUM_REGS words of LARGURA bits, NUM_LEITURA combinational read ports and one write port fed by four prioritised sources (ULA, Dado, jump link address, load from Memoria). It adds a multi-cycle sweep-clear state machine, optional read bypass, optional hardwired-zero R0 and conflict/drop status outputs. It sits between decode/control and the ULA/memory stages.

Parameters:
LARGURA, 32, data word width in bits
NUM_REGS, 32, number of registers; power of two, >= 2
NUM_LEITURA, 2, number of read ports, >= 1
ZERO_R0, 1, 1: register 0 reads 0 and ignores writes
BYPASS, 1, 1: read port addressing an accepted same-cycle write returns the write data
Derived localparam AW = $clog2(NUM_REGS).

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous, active-low reset
Limpar  in  1  request sweep-clear of all registers
FlagLoad  in  1  write Memoria
FlagJump  in  1  write EnderecoPC (link)
FlagEscrita  in  1  write Dado
FlagULA  in  1  write EscritaULA
RegEscrita  in  AW  write address
Memoria  in  LARGURA  load data
EnderecoPC  in  LARGURA  link address
Dado  in  LARGURA  generic write data
EscritaULA  in  LARGURA  ULA result
RegLeitura  in  NUM_LEITURA*AW  read addresses, port k at bits [k*AW +: AW]
DadoLeitura  out  NUM_LEITURA*LARGURA  read data, port k at bits [k*LARGURA +: LARGURA]
Saida  out  LARGURA  stored contents of Banco[RegEscrita]
Pronto  out  1  1 = idle, writes accepted
Conflito  out  1  registered 1-cycle pulse: >1 write flag in previous cycle
Descartado  out  1  registered 1-cycle pulse: write flag(s) dropped during sweep in previous cycle

Behaviour:
- Reset (resetn=0, async): all registers 0, state OCIOSO, counter 0, Pronto=1, Conflito=0, Descartado=0. Reset mid-sweep aborts it; bank fully zero.
- Write select, fixed priority: FlagULA > FlagEscrita > FlagJump > FlagLoad. Exactly one source written per edge.
- Write accepted at posedge when state OCIOSO and any flag high; Banco[RegEscrita] <= selected data. With ZERO_R0=1 and RegEscrita=0 the write is silently ignored (no Descartado).
- Conflito <= 1 on edge where two or more flags high (any state), else 0.
- FSM states: OCIOSO, LIMPANDO.
  - OCIOSO and Limpar=1 -> LIMPANDO, counter <= 0. Any write flag in that same cycle is still accepted (request edge is last accepted write).
  - LIMPANDO: each edge Banco[counter] <= 0, counter++. When counter == NUM_REGS-1: clear it, go OCIOSO, counter <= 0. Sweep = NUM_REGS cycles; Pronto high again on cycle NUM_REGS+1 after request.
  - LIMPANDO ignores Limpar. Write flags dropped; Descartado <= 1 for each such edge.
- Pronto = (state == OCIOSO), combinational from state.
- Reads combinational. DadoLeitura port k = Banco[RegLeitura_k]; 0 if ZERO_R0 and address 0. With BYPASS=1 and write accepted this cycle to same non-zero-gated address, port returns selected write data. During LIMPANDO reads return stored contents (no bypass).
- Saida = stored Banco[RegEscrita], never bypassed; 0 for address 0 when ZERO_R0.
- Widths: all data paths exactly LARGURA; no extension or truncation.

Test Plan:
- Reset then FlagULA=1, RegEscrita=5, EscritaULA=0x0000_00AA; next cycle read port0 addr 5 -> 0xAA, Saida=0xAA, Conflito=0.
- All four flags high, RegEscrita=3, EscritaULA=1, Dado=2, EnderecoPC=3, Memoria=4 -> Banco[3]=1, Conflito=1 for exactly one cycle; repeat with only FlagJump+FlagLoad -> Banco[3]=3.
- ZERO_R0=1: FlagEscrita to reg 0 with Dado=0xFFFF_FFFF -> port reads 0, Saida=0, Descartado=0; BYPASS=1 same-cycle write reg 7 Dado=0x1234 with port1 addr 7 -> DadoLeitura port1=0x1234 before edge.
- Fill regs 1..31 with index value, pulse Limpar -> Pronto=0 for 32 cycles, FlagEscrita during sweep -> Descartado=1 and no write; afterward all regs read 0, Pronto=1.
- Assert resetn=0 mid-sweep (counter=10, regs 20..31 nonzero) asynchronously -> immediate all zeros, Pronto=1 without clock edge.
- NUM_REGS=8, NUM_LEITURA=3, LARGURA=16 instance: write reg 7=0xBEEF, read on all three ports -> 0xBEEF each; sweep takes 8 cycles.

Source files
------------

// File: rtl/banco_registradores_param.sv
// banco_registradores_param
// Parametrised register bank: NUM_LEITURA combinational read ports, one
// prioritised write port (ULA > Dado > jump link > load), a multi-cycle
// sweep-clear state machine, optional read bypass and hardwired-zero R0.
// Conflito/Descartado are registered one-cycle status pulses.

module banco_registradores_param #(
  parameter int LARGURA     = 32,
  parameter int NUM_REGS    = 32,
  parameter int NUM_LEITURA = 2,
  parameter int ZERO_R0     = 1,
  parameter int BYPASS      = 1,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           Limpar,
  input  logic                           FlagLoad,
  input  logic                           FlagJump,
  input  logic                           FlagEscrita,
  input  logic                           FlagULA,
  input  logic [AW-1:0]                  RegEscrita,
  input  logic [LARGURA-1:0]             Memoria,
  input  logic [LARGURA-1:0]             EnderecoPC,
  input  logic [LARGURA-1:0]             Dado,
  input  logic [LARGURA-1:0]             EscritaULA,
  input  logic [NUM_LEITURA*AW-1:0]      RegLeitura,
  output logic [NUM_LEITURA*LARGURA-1:0] DadoLeitura,
  output logic [LARGURA-1:0]             Saida,
  output logic                           Pronto,
  output logic                           Conflito,
  output logic                           Descartado
);

  localparam logic [0:0]    OCIOSO   = 1'b0;
  localparam logic [0:0]    LIMPANDO = 1'b1;
  localparam logic [AW-1:0] CONT_ZERO = AW'(0);
  localparam logic [AW-1:0] CONT_UM   = AW'(1);
  localparam logic [AW-1:0] CONT_FIM  = AW'(NUM_REGS - 1);

  logic [LARGURA-1:0] banco_q [NUM_REGS];
  logic [LARGURA-1:0] banco_d [NUM_REGS];
  logic [0:0]         estado_q;
  logic [0:0]         estado_d;
  logic [AW-1:0]      cont_q;
  logic [AW-1:0]      cont_d;
  logic               conflito_q;
  logic               conflito_d;
  logic               descartado_q;
  logic               descartado_d;

  logic [3:0]         flags_s;
  logic               alguma_s;
  logic               r0_alvo_s;
  logic               aceita_s;
  logic [LARGURA-1:0] dado_sel_s;

  // Write source selection by fixed priority and acceptance decision.
  always_comb begin
    flags_s  = {FlagULA, FlagEscrita, FlagJump, FlagLoad};
    alguma_s = |flags_s;
    if (FlagULA) begin
      dado_sel_s = EscritaULA;
    end else if (FlagEscrita) begin
      dado_sel_s = Dado;
    end else if (FlagJump) begin
      dado_sel_s = EnderecoPC;
    end else if (FlagLoad) begin
      dado_sel_s = Memoria;
    end else begin
      dado_sel_s = {LARGURA{1'b0}};
    end
    // Writes to R0 are silently swallowed when it is hardwired to zero.
    r0_alvo_s = (ZERO_R0 != 0) && (RegEscrita == CONT_ZERO);
    aceita_s  = (estado_q == OCIOSO) && alguma_s && !r0_alvo_s;
    // Two or more flags set: clearing the lowest set bit leaves something.
    conflito_d = ((flags_s & (flags_s - 4'd1)) != 4'd0);
  end

  // Sweep-clear state machine and dropped-write detection.
  always_comb begin
    estado_d     = estado_q;
    cont_d       = cont_q;
    descartado_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        cont_d = CONT_ZERO;
        if (Limpar) begin
          estado_d = LIMPANDO;
        end else begin
          estado_d = OCIOSO;
        end
      end
      LIMPANDO: begin
        // Limpar is ignored here; any write flag is dropped and reported.
        descartado_d = alguma_s;
        if (cont_q == CONT_FIM) begin
          estado_d = OCIOSO;
          cont_d   = CONT_ZERO;
        end else begin
          estado_d = LIMPANDO;
          cont_d   = cont_q + CONT_UM;
        end
      end
      default: begin
        estado_d = OCIOSO;
        cont_d   = CONT_ZERO;
      end
    endcase
  end

  // Next contents of every register: sweep clear or accepted write.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((estado_q == LIMPANDO) && (cont_q == AW'(i))) begin
        banco_d[i] = {LARGURA{1'b0}};
      end else if (aceita_s && (RegEscrita == AW'(i))) begin
        banco_d[i] = dado_sel_s;
      end else begin
        banco_d[i] = banco_q[i];
      end
    end
  end

  // State, counter, bank and status pulse registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      estado_q     <= OCIOSO;
      cont_q       <= CONT_ZERO;
      conflito_q   <= 1'b0;
      descartado_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        banco_q[i] <= {LARGURA{1'b0}};
      end
    end else begin
      estado_q     <= estado_d;
      cont_q       <= cont_d;
      conflito_q   <= conflito_d;
      descartado_q <= descartado_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        banco_q[i] <= banco_d[i];
      end
    end
  end

  // Read ports: R0 gating first, then same-cycle bypass, else stored value.
  for (genvar k = 0; k < NUM_LEITURA; k++) begin : g_leitura
    logic [AW-1:0]      end_s;
    logic [LARGURA-1:0] val_s;

    // Combinational read of port k.
    always_comb begin
      end_s = RegLeitura[k*AW +: AW];
      if ((ZERO_R0 != 0) && (end_s == CONT_ZERO)) begin
        val_s = {LARGURA{1'b0}};
      end else if ((BYPASS != 0) && aceita_s && (end_s == RegEscrita)) begin
        val_s = dado_sel_s;
      end else begin
        val_s = banco_q[end_s];
      end
    end

    assign DadoLeitura[k*LARGURA +: LARGURA] = val_s;
  end

  // Stored contents at the write address; never bypassed.
  always_comb begin
    if ((ZERO_R0 != 0) && (RegEscrita == CONT_ZERO)) begin
      Saida = {LARGURA{1'b0}};
    end else begin
      Saida = banco_q[RegEscrita];
    end
  end

  assign Pronto     = (estado_q == OCIOSO);
  assign Conflito   = conflito_q;
  assign Descartado = descartado_q;

endmodule
